writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Writeback buffer between the MEM stage and the register array. Accepts results over valid/ready,
//  queues them in a small in-order FIFO and issues at most one register write per cycle on the
//  WB_DataIn / WB_RegSel / L_R0 / L_RN write port. Drives L_R0 and L_RN together to clear all registers.
//  Optional bypass port returns the newest value still pending for a register that decode reads.
// PARAMETERS
//  DEPTH  4   FIFO entries, power of 2, >=2; AW = $clog2(DEPTH)
//  DW     16  data width
// PORTS
//  clk         in   1       system clock, all state on posedge
//  rst_n       in   1       asynchronous, active-low reset
//  mem_valid   in   1       MEM stage offers a result
//  mem_ready   out  1       stage accepts; transfer = mem_valid & mem_ready at posedge
//  mem_data    in   DW      result value
//  mem_regsel  in   3       destination register index (used when mem_dest_r0=0)
//  mem_dest_r0 in   1       1: write R0 via L_R0 (mem_regsel ignored)
//  mem_clear   in   1       1: clear all registers (overrides mem_dest_r0, data ignored)
//  wb_hold     in   1       1: freeze draining; output write is not issued
//  WB_DataIn   out  DW      write data to register array
//  WB_RegSel   out  3       write index to register array
//  L_R0        out  1       load R0 strobe
//  L_RN        out  1       load RN strobe
//  fwd_sel     in   3       bypass query register index
//  fwd_hit     out  1       a pending write to fwd_sel exists
//  fwd_data    out  DW      value of newest such pending write
//  wb_pending  out  AW+1    entries in FIFO (excludes the output register)
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFO empty, pointers 0, WB_DataIn=0, WB_RegSel=0, L_R0=0, L_RN=0,
//    wb_pending=0. Queued and in-flight entries are discarded; no write is issued after release.
//  - Entry = {data, idx, kind}; kind NORM (L_RN), R0 (L_R0, idx forced 0), CLR (both, data 0).
//  - pop = !empty & !wb_hold. mem_ready = (wb_pending < DEPTH) | pop (purely combinational).
//  - Edge with pop: head entry loads the output register; the strobe pattern for its kind is held
//    for exactly one cycle. Edge without pop: L_R0=L_RN=0; WB_DataIn/WB_RegSel keep their last value.
//  - Latency: a transfer at edge N into an empty FIFO with wb_hold=0 drives the strobes during
//    cycle N+1..N+2; the register array captures at edge N+2. Writes leave in arrival order.
//  - Simultaneous push and pop: both happen; count unchanged (legal when full).
//  - Push while full without pop: blocked by mem_ready=0; the MEM stage must hold its inputs.
//  - Pointers wrap modulo DEPTH; wb_pending ranges 0..DEPTH.
//  - Effective dest of an entry: NORM -> idx, R0 -> 0, CLR -> matches every index with data 0.
//  - Bypass (combinational): candidates are the output register (only while its strobe is high)
//    and all FIFO entries; the newest matching candidate wins (FIFO tail side newest, output reg oldest).
//    No match -> fwd_hit=0, fwd_data=0. An entry accepted at the current edge is visible
//    from the next cycle onward.
// CONFIGURATION
//  WB_FWD_EN defined: bypass logic as above.
//  WB_FWD_EN undefined: fwd_hit tied 0, fwd_data tied 0, fwd_sel unused; no compare logic built.
// TESTING
//  1 Empty, push {0x1234, sel 5, NORM} -> 2 cycles later L_RN=1 for 1 cycle, WB_RegSel=5, WB_DataIn=0x1234.
//  2 wb_hold=1, push 4 entries -> mem_ready=0, wb_pending=4; drop hold -> 4 writes on consecutive cycles in order.
//  3 Pending NORM writes to R3: 0x00AA then 0x00BB, hold=1, fwd_sel=3 -> fwd_hit=1, fwd_data=0x00BB; after drain -> fwd_hit=0.
//  4 Push CLR -> L_R0=L_RN=1 same cycle, WB_DataIn=0; while pending, fwd_sel=6 -> fwd_hit=1, fwd_data=0.
//  5 FIFO full, hold=0, mem_valid=1 -> accepted every cycle, wb_pending stays 4, one write per cycle.
//  6 3 entries pending, pulse rst_n=0 mid-cycle -> all outputs 0 immediately; no strobes after release.

Source files
------------

// File: rtl/writeback_stage.sv
// writeback_stage: in-order writeback FIFO feeding the register-array write port (WB_DataIn/WB_RegSel/L_R0/L_RN).
// Optional decode bypass is built only when WB_FWD_EN is defined.
`default_nettype none

module writeback_stage #(
   parameter int DEPTH = 4,
   parameter int DW    = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          mem_valid,
   output logic          mem_ready,
   input  logic [DW-1:0] mem_data,
   input  logic [2:0]    mem_regsel,
   input  logic          mem_dest_r0,
   input  logic          mem_clear,
   input  logic          wb_hold,
   output logic [DW-1:0] WB_DataIn,
   output logic [2:0]    WB_RegSel,
   output logic          L_R0,
   output logic          L_RN,
   input  logic [2:0]    fwd_sel,
   output logic          fwd_hit,
   output logic [DW-1:0] fwd_data,
   output logic [AW:0]   wb_pending
);

   typedef enum logic [1:0] {
      K_NORM = 2'd0,
      K_R0   = 2'd1,
      K_CLR  = 2'd2
   } kind_t;

   logic [DW-1:0] data_mem_q [DEPTH];
   logic [2:0]    idx_mem_q  [DEPTH];
   kind_t         kind_mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;

   logic [DW-1:0] wb_data_q;
   logic [2:0]    wb_sel_q;
   logic          l_r0_q;
   logic          l_rn_q;

   logic          push;
   logic          pop;
   kind_t         in_kind;
   logic [DW-1:0] in_data;
   logic [2:0]    in_idx;

   assign pop       = (count_q != '0) && !wb_hold;
   assign mem_ready = (count_q < (AW+1)'(DEPTH)) || pop;
   assign push      = mem_valid && mem_ready;

   // Clear wins over R0; both force the stored index to 0 so the entry is self-describing.
   always_comb begin
      in_kind = K_NORM;
      in_data = mem_data;
      in_idx  = mem_regsel;
      if (mem_clear) begin
         in_kind = K_CLR;
         in_data = '0;
         in_idx  = '0;
      end else if (mem_dest_r0) begin
         in_kind = K_R0;
         in_idx  = '0;
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_mem_q[wr_ptr_q] <= in_data;
         idx_mem_q[wr_ptr_q]  <= in_idx;
         kind_mem_q[wr_ptr_q] <= in_kind;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wb_data_q <= '0;
         wb_sel_q  <= '0;
         l_r0_q    <= 1'b0;
         l_rn_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (pop) begin
            wb_data_q <= data_mem_q[rd_ptr_q];
            wb_sel_q  <= idx_mem_q[rd_ptr_q];
            l_r0_q    <= (kind_mem_q[rd_ptr_q] != K_NORM);
            l_rn_q    <= (kind_mem_q[rd_ptr_q] != K_R0);
         end else begin
            l_r0_q <= 1'b0;
            l_rn_q <= 1'b0;
         end
      end
   end

   assign WB_DataIn  = wb_data_q;
   assign WB_RegSel  = wb_sel_q;
   assign L_R0       = l_r0_q;
   assign L_RN       = l_rn_q;
   assign wb_pending = count_q;

`ifdef WB_FWD_EN
   // Scan oldest to newest so a later match overrides an earlier one.
   always_comb begin
      logic [AW-1:0] slot;
      fwd_hit  = 1'b0;
      fwd_data = '0;
      slot     = '0;
      if (l_r0_q && l_rn_q) begin
         fwd_hit  = 1'b1;
         fwd_data = '0;
      end else if ((l_r0_q && fwd_sel == 3'd0) || (l_rn_q && fwd_sel == wb_sel_q)) begin
         fwd_hit  = 1'b1;
         fwd_data = wb_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         slot = rd_ptr_q + AW'(i);
         if ((AW+1)'(i) < count_q) begin
            if (kind_mem_q[slot] == K_CLR) begin
               fwd_hit  = 1'b1;
               fwd_data = '0;
            end else if (idx_mem_q[slot] == fwd_sel) begin
               fwd_hit  = 1'b1;
               fwd_data = data_mem_q[slot];
            end
         end
      end
   end
`else
   logic unused_fwd_sel;
   assign unused_fwd_sel = ^fwd_sel;
   assign fwd_hit        = 1'b0;
   assign fwd_data       = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected writes are queued on acceptance and matched by a monitor.
`default_nettype none

module tb_writeback_stage;

   localparam int DW = 16;
`ifdef WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mem_valid = 1'b0;
   logic          mem_ready;
   logic [DW-1:0] mem_data = '0;
   logic [2:0]    mem_regsel = '0;
   logic          mem_dest_r0 = 1'b0;
   logic          mem_clear = 1'b0;
   logic          wb_hold = 1'b0;
   logic [DW-1:0] WB_DataIn;
   logic [2:0]    WB_RegSel;
   logic          L_R0;
   logic          L_RN;
   logic [2:0]    fwd_sel = '0;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;
   logic [2:0]    wb_pending;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic [2:0]    sel;
      logic          r0;
      logic          rn;
      logic          chk_sel;
   } exp_t;

   exp_t sb[$];

   writeback_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_data   (mem_data),
      .mem_regsel (mem_regsel),
      .mem_dest_r0(mem_dest_r0),
      .mem_clear  (mem_clear),
      .wb_hold    (wb_hold),
      .WB_DataIn  (WB_DataIn),
      .WB_RegSel  (WB_RegSel),
      .L_R0       (L_R0),
      .L_RN       (L_RN),
      .fwd_sel    (fwd_sel),
      .fwd_hit    (fwd_hit),
      .fwd_data   (fwd_data),
      .wb_pending (wb_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference view of what one accepted result should write.
   function automatic exp_t model(input logic [DW-1:0] d, input logic [2:0] s,
                                  input logic r0, input logic clr);
      exp_t e;
      if (clr) begin
         e = '{data: '0, sel: 3'd0, r0: 1'b1, rn: 1'b1, chk_sel: 1'b0};
      end else if (r0) begin
         e = '{data: d, sel: 3'd0, r0: 1'b1, rn: 1'b0, chk_sel: 1'b1};
      end else begin
         e = '{data: d, sel: s, r0: 1'b0, rn: 1'b1, chk_sel: 1'b1};
      end
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (L_R0 || L_RN) begin
            if (sb.size() == 0) begin
               check("spurious_write", {30'd0, L_R0, L_RN}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("wr_strobes", {30'd0, L_R0, L_RN}, {30'd0, e.r0, e.rn});
               check("wr_data", 32'(WB_DataIn), 32'(e.data));
               if (e.chk_sel) check("wr_regsel", 32'(WB_RegSel), 32'(e.sel));
            end
         end
         if (mem_valid && mem_ready) sb.push_back(model(mem_data, mem_regsel, mem_dest_r0, mem_clear));
      end
   end

   // Called just after a posedge; returns just after the accepting edge with mem_valid low.
   task automatic push(input logic [DW-1:0] d, input logic [2:0] s, input logic r0, input logic clr);
      bit done = 1'b0;
      mem_valid   = 1'b1;
      mem_data    = d;
      mem_regsel  = s;
      mem_dest_r0 = r0;
      mem_clear   = clr;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         if (mem_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) check("push_timeout", 32'd0, 32'd1);
      mem_valid = 1'b0;
   endtask

   task automatic drain();
      bit done = 1'b0;
      wb_hold = 1'b0;
      for (int t = 0; t < 40 && !done; t++) begin
         @(negedge clk);
         if (sb.size() == 0) done = 1'b1;
      end
      if (!done) check("drain_timeout", 32'(sb.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_data", 32'(WB_DataIn), 32'd0);
      check("rst_regsel", 32'(WB_RegSel), 32'd0);
      check("rst_strobes", {30'd0, L_R0, L_RN}, 32'd0);
      check("rst_pending", 32'(wb_pending), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: single write, two-cycle latency, one-cycle strobe
      push(16'h1234, 3'd5, 1'b0, 1'b0);
      @(negedge clk);
      check("t1_no_strobe_yet", {30'd0, L_R0, L_RN}, 32'd0);
      @(negedge clk);
      check("t1_strobe", {30'd0, L_R0, L_RN}, 32'd1);
      check("t1_regsel", 32'(WB_RegSel), 32'd5);
      check("t1_data", 32'(WB_DataIn), 32'h1234);
      @(negedge clk);
      check("t1_strobe_off", {30'd0, L_R0, L_RN}, 32'd0);
      check("t1_data_held", 32'(WB_DataIn), 32'h1234);
      @(posedge clk);
      #1;

      // 2: hold fills the FIFO, then four back-to-back writes in order
      wb_hold = 1'b1;
      push(16'h1111, 3'd1, 1'b0, 1'b0);
      push(16'h2222, 3'd7, 1'b1, 1'b0);
      push(16'h3333, 3'd2, 1'b0, 1'b0);
      push(16'h4444, 3'd7, 1'b0, 1'b0);
      @(negedge clk);
      check("t2_ready_full", 32'(mem_ready), 32'd0);
      check("t2_pending_full", 32'(wb_pending), 32'd4);
      @(posedge clk);
      #1;
      wb_hold = 1'b0;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("t2_back_to_back", 32'(L_R0 | L_RN), 32'd1);
      end
      @(negedge clk);
      check("t2_idle_after", {30'd0, L_R0, L_RN}, 32'd0);
      check("t2_pending_empty", 32'(wb_pending), 32'd0);
      @(posedge clk);
      #1;

      // 3: bypass picks the newest pending write to R3
      wb_hold = 1'b1;
      push(16'h00AA, 3'd3, 1'b0, 1'b0);
      push(16'h00BB, 3'd3, 1'b0, 1'b0);
      fwd_sel = 3'd3;
      @(negedge clk);
      check("t3_fwd_hit", 32'(fwd_hit), FWD ? 32'd1 : 32'd0);
      check("t3_fwd_data", 32'(fwd_data), FWD ? 32'h00BB : 32'd0);
      fwd_sel = 3'd4;
      #1;
      check("t3_fwd_miss", 32'(fwd_hit), 32'd0);
      fwd_sel = 3'd3;
      @(posedge clk);
      #1;
      drain();
      @(negedge clk);
      check("t3_fwd_after_drain", 32'(fwd_hit), 32'd0);
      @(posedge clk);
      #1;

      // 4: clear entry overrides R0 select and data, matches every index
      wb_hold = 1'b1;
      push(16'h0077, 3'd6, 1'b0, 1'b0);
      push(16'hFFFF, 3'd3, 1'b1, 1'b1);
      fwd_sel = 3'd6;
      @(negedge clk);
      check("t4_fwd_hit", 32'(fwd_hit), FWD ? 32'd1 : 32'd0);
      check("t4_fwd_data", 32'(fwd_data), 32'd0);
      @(posedge clk);
      #1;
      drain();

      // 5: full FIFO keeps accepting while draining
      wb_hold = 1'b1;
      for (int k = 0; k < 4; k++) push(16'h0100 + 16'(k), 3'(k + 1), 1'b0, 1'b0);
      wb_hold = 1'b0;
      for (int k = 0; k < 6; k++) begin
         mem_valid  = 1'b1;
         mem_data   = 16'h0200 + 16'(k);
         mem_regsel = 3'(k);
         mem_dest_r0 = 1'b0;
         mem_clear  = 1'b0;
         @(negedge clk);
         check("t5_ready", 32'(mem_ready), 32'd1);
         check("t5_pending", 32'(wb_pending), 32'd4);
         @(posedge clk);
         #1;
      end
      mem_valid = 1'b0;
      drain();

      // 6: async reset discards pending entries
      wb_hold = 1'b1;
      push(16'h0A0A, 3'd1, 1'b0, 1'b0);
      push(16'h0B0B, 3'd2, 1'b0, 1'b0);
      push(16'h0C0C, 3'd3, 1'b0, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_data", 32'(WB_DataIn), 32'd0);
      check("t6_regsel", 32'(WB_RegSel), 32'd0);
      check("t6_strobes", {30'd0, L_R0, L_RN}, 32'd0);
      check("t6_pending", 32'(wb_pending), 32'd0);
      sb.delete();
      wb_hold = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("t6_no_write", {30'd0, L_R0, L_RN}, 32'd0);
      end
      check("t6_pending_after", 32'(wb_pending), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
